// File: rtl/rv32_types.sv
// rtl/rv32_types.sv - shared RV32 pipeline buffer types for the memory stage
package rv32_types;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_op_t;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} mem_size_t;
  typedef enum logic [1:0] {FAULT_NONE, FAULT_MISALIGNED, FAULT_BUS, FAULT_TIMEOUT} mem_fault_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    mem_op_t    mem_op;
    mem_size_t  mem_size;
    logic       mem_unsigned;
  } decoded_instr_t;

  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    instr;
    decoded_instr_t decoded_instr;
    logic [31:0]    wb_result;
    logic [31:0]    store_data;
  } exec_buffer_data_t;

  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    instr;
    decoded_instr_t decoded_instr;
    logic [31:0]    wb_result;
    mem_fault_t     fault;
  } mem_buffer_data_t;

  function automatic decoded_instr_t create_nop_ctrl();
    decoded_instr_t c;
    c.rd           = 5'd0;
    c.reg_write    = 1'b0;
    c.mem_op       = MEM_NONE;
    c.mem_size     = SIZE_W;
    c.mem_unsigned = 1'b0;
    return c;
  endfunction

  // Bubble and reset value of the MEM/WB buffer
  function automatic mem_buffer_data_t create_nop_mem_data();
    mem_buffer_data_t m;
    m.pc            = 32'd0;
    m.instr         = RV_NOP;
    m.decoded_instr = create_nop_ctrl();
    m.wb_result     = 32'd0;
    m.fault         = FAULT_NONE;
    return m;
  endfunction

endpackage

// File: rtl/rv32_mem_access_stage_if.sv
// rtl/rv32_mem_access_stage_if.sv - data-memory request/response bus
interface rv32_mem_access_stage_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_req_we;
  logic [ADDR_WIDTH-1:0] dmem_req_addr;
  logic [31:0]           dmem_req_wdata;
  logic [3:0]            dmem_req_strb;
  logic                  dmem_rsp_valid;
  logic [31:0]           dmem_rsp_rdata;
  logic                  dmem_rsp_err;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_strb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_strb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );
endinterface

// File: rtl/rv32_mem_lane_align.sv
// rtl/rv32_mem_lane_align.sv - byte-lane store steering and load extract/extend
module rv32_mem_lane_align
  import rv32_types::*;
(
  input  logic [1:0]  addr_lo_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  strb_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    wdata_o      = store_data_i;
    strb_o       = 4'b1111;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_B: begin
        wdata_o     = {4{store_data_i[7:0]}};
        strb_o      = 4'b0001 << addr_lo_i;
        load_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      end
      SIZE_H: begin
        wdata_o      = {2{store_data_i[15:0]}};
        strb_o       = 4'b0011 << addr_lo_i;
        load_data_o  = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      default: misaligned_o = (addr_lo_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/rv32_mem_access_stage.sv
// rtl/rv32_mem_access_stage.sv - RV32 MEM stage: issues loads/stores and fills the MEM/WB buffer
module rv32_mem_access_stage
  import rv32_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  exec_buffer_data_t exec_data_i,
  output mem_buffer_data_t  mem_data_o,
  output logic              stall_o,
  rv32_mem_access_stage_if.master dmem
);

  typedef enum logic {ST_IDLE, ST_WAIT_RSP} state_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                state_q;
  logic [CNT_W-1:0]      tmo_cnt_q;
  mem_buffer_data_t      mem_data_q;
  mem_buffer_data_t      mem_data_d;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  is_mem;
  logic                  misaligned;
  logic                  issue;
  logic                  rsp_hit;
  logic                  tmo_hit;
  logic [31:0]           load_data;
  logic [31:0]           wdata;
  logic [3:0]            strb;

  rv32_mem_lane_align u_lane_align (
    .addr_lo_i    (addr[1:0]),
    .size_i       (exec_data_i.decoded_instr.mem_size),
    .unsigned_i   (exec_data_i.decoded_instr.mem_unsigned),
    .store_data_i (exec_data_i.store_data),
    .rdata_i      (dmem.dmem_rsp_rdata),
    .wdata_o      (wdata),
    .strb_o       (strb),
    .load_data_o  (load_data),
    .misaligned_o (misaligned)
  );

  assign addr    = exec_data_i.wb_result[ADDR_WIDTH-1:0];
  assign is_mem  = exec_data_i.decoded_instr.mem_op != MEM_NONE;
  assign issue   = !reset && state_q == ST_IDLE && is_mem && !misaligned;
  assign rsp_hit = state_q == ST_WAIT_RSP && dmem.dmem_rsp_valid;
  // A response in the final timeout cycle still wins over the timeout
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && state_q == ST_WAIT_RSP && !dmem.dmem_rsp_valid
                   && tmo_cnt_q == CNT_LAST;
  assign stall_o = !reset && (issue || (state_q == ST_WAIT_RSP && !rsp_hit && !tmo_hit));

  assign dmem.dmem_req_valid = issue;
  assign dmem.dmem_req_we    = exec_data_i.decoded_instr.mem_op == MEM_STORE;
  assign dmem.dmem_req_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign dmem.dmem_req_wdata = wdata;
  assign dmem.dmem_req_strb  = strb;
  assign mem_data_o          = mem_data_q;

  always_comb begin
    mem_data_d.pc            = exec_data_i.pc;
    mem_data_d.instr         = exec_data_i.instr;
    mem_data_d.decoded_instr = exec_data_i.decoded_instr;
    mem_data_d.wb_result     = exec_data_i.wb_result;
    mem_data_d.fault         = FAULT_NONE;
    if (stall_o) begin
      mem_data_d = create_nop_mem_data();
    end else if (state_q == ST_WAIT_RSP) begin
      mem_data_d.wb_result = 32'd0;
      if (!dmem.dmem_rsp_valid) begin
        mem_data_d.fault = FAULT_TIMEOUT;
      end else if (dmem.dmem_rsp_err) begin
        mem_data_d.fault = FAULT_BUS;
      end else if (exec_data_i.decoded_instr.mem_op == MEM_LOAD) begin
        mem_data_d.wb_result = load_data;
      end
    end else if (is_mem && misaligned) begin
      mem_data_d.wb_result = 32'd0;
      mem_data_d.fault     = FAULT_MISALIGNED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmo_cnt_q  <= '0;
      mem_data_q <= create_nop_mem_data();
    end else begin
      mem_data_q <= mem_data_d;
      case (state_q)
        ST_IDLE: begin
          if (issue && dmem.dmem_req_ready) begin
            state_q   <= ST_WAIT_RSP;
            tmo_cnt_q <= '0;
          end
        end
        default: begin
          if (rsp_hit || tmo_hit) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_access_stage.sv
// tb/tb_rv32_mem_access_stage.sv - scoreboard bench for the RV32 memory access stage
module tb_rv32_mem_access_stage;
  import rv32_types::*;

  localparam int TMO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  logic              clk = 1'b0;
  logic              reset;
  exec_buffer_data_t exec_data;
  mem_buffer_data_t  mem_data;
  logic              stall;

  rv32_mem_access_stage_if #(.ADDR_WIDTH(32)) dmem_if ();

  rv32_mem_access_stage #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .exec_data_i (exec_data),
    .mem_data_o  (mem_data),
    .stall_o     (stall),
    .dmem        (dmem_if)
  );

  always #5 clk = ~clk;

  mem_buffer_data_t sb_q[$];
  req_t             req_q[$];
  mem_buffer_data_t exp_r;
  req_t             rq;
  int               total = 0;
  int               bad = 0;
  bit               mon_en = 1'b0;
  bit               stray = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic mem_buffer_data_t bubble();
    mem_buffer_data_t b;
    b.pc = 32'd0; b.instr = RV_NOP; b.decoded_instr = create_nop_ctrl();
    b.wb_result = 32'd0; b.fault = FAULT_NONE;
    return b;
  endfunction

  function automatic int size_bytes(mem_size_t s);
    return (s == SIZE_B) ? 1 : (s == SIZE_H) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(logic [31:0] a, mem_size_t s);
    return (a % size_bytes(s)) != 0;
  endfunction

  function automatic logic [31:0] load_value(logic [31:0] rdata, logic [31:0] a, mem_size_t s, logic uns);
    int n;
    logic [31:0] v;
    n = size_bytes(s);
    if (n == 4) return rdata;
    v = (rdata >> (8 * (a % 4))) & ((32'h1 << (8 * n)) - 1);
    if (!uns && v[8*n-1]) v = v - (32'h1 << (8 * n));
    return v;
  endfunction

  function automatic req_t exp_req(exec_buffer_data_t e);
    req_t r;
    logic [31:0] a;
    a = e.wb_result;
    r.we   = e.decoded_instr.mem_op == MEM_STORE;
    r.addr = a & 32'hFFFF_FFFC;
    case (e.decoded_instr.mem_size)
      SIZE_B:  begin r.wdata = (e.store_data & 32'hFF) * 32'h0101_0101; r.strb = 4'(1 << (a % 4)); end
      SIZE_H:  begin r.wdata = (e.store_data & 32'hFFFF) * 32'h0001_0001; r.strb = 4'(3 << (a % 4)); end
      default: begin r.wdata = e.store_data; r.strb = 4'hF; end
    endcase
    return r;
  endfunction

  function automatic exec_buffer_data_t make_exec(mem_op_t op, mem_size_t sz, logic uns,
                                                  logic [31:0] res, logic [31:0] sd);
    exec_buffer_data_t e;
    e.pc = $urandom & 32'hFFFF_FFFC;
    e.instr = $urandom;
    e.instr[6:0] = (op == MEM_LOAD) ? 7'b0000011 : (op == MEM_STORE) ? 7'b0100011 : 7'b0110011;
    e.decoded_instr.rd = 5'($urandom);
    e.decoded_instr.reg_write = (op != MEM_STORE);
    e.decoded_instr.mem_op = op;
    e.decoded_instr.mem_size = sz;
    e.decoded_instr.mem_unsigned = uns;
    e.wb_result = res;
    e.store_data = sd;
    return e;
  endfunction

  task automatic issue(input exec_buffer_data_t e, input int rdy_dly, input int rsp_dly,
                       input logic err, input logic [31:0] rdata);
    mem_buffer_data_t x;
    bit mem_ok;
    mem_op_t op;
    op = e.decoded_instr.mem_op;
    mem_ok = (op != MEM_NONE) && !is_misaligned(e.wb_result, e.decoded_instr.mem_size);
    x.pc = e.pc; x.instr = e.instr; x.decoded_instr = e.decoded_instr;
    x.wb_result = 32'd0; x.fault = FAULT_NONE;
    if (op == MEM_NONE) x.wb_result = e.wb_result;
    else if (!mem_ok) x.fault = FAULT_MISALIGNED;
    else if (rsp_dly >= TMO) x.fault = FAULT_TIMEOUT;
    else if (err) x.fault = FAULT_BUS;
    else if (op == MEM_LOAD) x.wb_result = load_value(rdata, e.wb_result, e.decoded_instr.mem_size,
                                                      e.decoded_instr.mem_unsigned);
    sb_q.push_back(x);
    exec_data = e;
    dmem_if.dmem_rsp_valid = stray;
    dmem_if.dmem_rsp_err = stray;
    if (!mem_ok) begin
      @(negedge clk);
      check("stall_nomem", 128'(stall), 128'(0));
      check("req_valid_nomem", 128'(dmem_if.dmem_req_valid), 128'(0));
      @(posedge clk); #1;
      dmem_if.dmem_rsp_valid = 1'b0;
      dmem_if.dmem_rsp_err = 1'b0;
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        dmem_if.dmem_req_ready = 1'b0;
        @(negedge clk);
        check("stall_req_wait", 128'(stall), 128'(1));
        check("req_valid_held", 128'(dmem_if.dmem_req_valid), 128'(1));
        @(posedge clk); #1;
      end
      dmem_if.dmem_req_ready = 1'b1;
      req_q.push_back(exp_req(e));
      @(negedge clk);
      check("stall_req", 128'(stall), 128'(1));
      @(posedge clk); #1;
      dmem_if.dmem_req_ready = 1'b0;
      dmem_if.dmem_rsp_valid = 1'b0;
      dmem_if.dmem_rsp_err = 1'b0;
      for (int w = 0; w < TMO; w++) begin
        if (w == rsp_dly) begin
          dmem_if.dmem_rsp_valid = 1'b1;
          dmem_if.dmem_rsp_err = err;
          dmem_if.dmem_rsp_rdata = rdata;
        end
        @(negedge clk);
        check("stall_rsp_wait", 128'(stall), 128'((w == rsp_dly || w == TMO - 1) ? 0 : 1));
        @(posedge clk); #1;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rsp_err = 1'b0;
        dmem_if.dmem_rsp_rdata = $urandom;
        if (w == rsp_dly) break;
      end
    end
  endtask

  // Result scoreboard: every non-NOP MEM/WB entry must match the oldest expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_data.instr !== RV_NOP) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL result_unexpected: got %h expected none", mem_data);
        end else begin
          exp_r = sb_q.pop_front();
          check("result", 128'(mem_data), 128'(exp_r));
        end
      end else begin
        check("bubble", 128'(mem_data), 128'(bubble()));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && dmem_if.dmem_req_valid && dmem_if.dmem_req_ready) begin
      if (req_q.size() == 0) begin
        total++; bad++;
        $display("FAIL req_unexpected: got addr %h expected none", dmem_if.dmem_req_addr);
      end else begin
        rq = req_q.pop_front();
        check("req_we", 128'(dmem_if.dmem_req_we), 128'(rq.we));
        check("req_addr", 128'(dmem_if.dmem_req_addr), 128'(rq.addr));
        if (rq.we) begin
          check("req_wdata", 128'(dmem_if.dmem_req_wdata), 128'(rq.wdata));
          check("req_strb", 128'(dmem_if.dmem_req_strb), 128'(rq.strb));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exec_buffer_data_t e;
    reset = 1'b1;
    dmem_if.dmem_req_ready = 1'b0;
    dmem_if.dmem_rsp_valid = 1'b0;
    dmem_if.dmem_rsp_rdata = 32'd0;
    dmem_if.dmem_rsp_err = 1'b0;
    exec_data = make_exec(MEM_LOAD, SIZE_W, 1'b0, 32'h100, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_data", 128'(mem_data), 128'(bubble()));
    check("reset_stall", 128'(stall), 128'(0));
    check("reset_req_valid", 128'(dmem_if.dmem_req_valid), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    issue(make_exec(MEM_LOAD, SIZE_W, 1'b0, 32'h100, 32'd0), 0, 0, 1'b0, 32'hDEAD_BEEF);
    issue(make_exec(MEM_LOAD, SIZE_B, 1'b0, 32'h103, 32'd0), 0, 0, 1'b0, 32'h80FF_FFFF);
    issue(make_exec(MEM_LOAD, SIZE_B, 1'b1, 32'h103, 32'd0), 0, 0, 1'b0, 32'h80FF_FFFF);
    issue(make_exec(MEM_STORE, SIZE_H, 1'b0, 32'h102, 32'h1234_ABCD), 0, 0, 1'b0, 32'd0);
    issue(make_exec(MEM_LOAD, SIZE_W, 1'b0, 32'h101, 32'd0), 0, 0, 1'b0, 32'd0);
    issue(make_exec(MEM_STORE, SIZE_H, 1'b0, 32'h101, 32'd0), 0, 0, 1'b0, 32'd0);
    issue(make_exec(MEM_LOAD, SIZE_H, 1'b0, 32'h202, 32'd0), 2, 1, 1'b0, 32'h8001_7FFF);
    issue(make_exec(MEM_LOAD, SIZE_W, 1'b0, 32'h300, 32'd0), 0, 10, 1'b0, 32'd0);
    stray = 1'b1;
    issue(make_exec(MEM_NONE, SIZE_W, 1'b0, 32'hCAFE_F00D, 32'd0), 0, 0, 1'b0, 32'd0);
    issue(make_exec(MEM_STORE, SIZE_B, 1'b0, 32'h401, 32'h0000_00A5), 2, 0, 1'b0, 32'd0);
    stray = 1'b0;
    issue(make_exec(MEM_LOAD, SIZE_W, 1'b0, 32'h500, 32'd0), 0, TMO - 1, 1'b0, 32'h1357_9BDF);
    issue(make_exec(MEM_LOAD, SIZE_W, 1'b0, 32'h504, 32'd0), 1, 2, 1'b1, 32'hFFFF_FFFF);

    // Reset while waiting for a response: the access is abandoned
    e = make_exec(MEM_LOAD, SIZE_W, 1'b0, 32'h600, 32'd0);
    exec_data = e;
    dmem_if.dmem_req_ready = 1'b1;
    req_q.push_back(exp_req(e));
    @(posedge clk); #1;
    dmem_if.dmem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset_wait_stall", 128'(stall), 128'(0));
    check("reset_wait_req_valid", 128'(dmem_if.dmem_req_valid), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 1'b1;
    issue(make_exec(MEM_NONE, SIZE_W, 1'b0, 32'h0BAD_0BAD, 32'd0), 0, 0, 1'b0, 32'd0);
    stray = 1'b0;

    for (int n = 0; n < 80; n++) begin
      stray = ($urandom_range(0, 3) == 0);
      issue(make_exec(mem_op_t'($urandom_range(0, 2)), mem_size_t'($urandom_range(0, 2)),
                      1'($urandom), $urandom, $urandom),
            $urandom_range(0, 2), $urandom_range(0, 5), ($urandom_range(0, 7) == 0), $urandom);
    end
    stray = 1'b0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    check("requests_drained", 128'(req_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
